aes_pipeline_ctrl: RTL
======================

AES_PIPELINE_CTRL -- requirements
Module: aes_pipeline_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_DEPTH, 64, number of 128-bit blocks expected per run.
REQ-002 SHALL have parameter CNT_W, 7, block-counter width; it SHALL satisfy 2**CNT_W > IMAGE_DEPTH.
REQ-003 SHALL have parameter GUARD_CYCLES, 20, idle cycles between config completion and reader start.
REQ-004 SHALL have parameter DRAIN_CYCLES, 16, cycles after writer_done before done is reported.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, 65535, watchdog limit per waiting state.
REQ-006 SHALL have port clk, input, 1, single clock for all logic.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, run request, sampled in IDLE or DONE.
REQ-009 SHALL have port abort, input, 1, return to IDLE from any state.
REQ-010 SHALL have port start_config, output, 1, one-cycle pulse to the AXI-Lite config block.
REQ-011 SHALL have port config_done, input, 1, config block finished.
REQ-012 SHALL have port reader_start, output, 1, one-cycle pulse to image_reader.
REQ-013 SHALL have port writer_done, input, 1, encrypted_writer finished.
REQ-014 SHALL have port wr_strobe, input, 1, writer BRAM write (bram_en && bram_we).
REQ-015 SHALL have ports busy, done, error, output, 1 each: run active, run complete (level), error latched.
REQ-016 SHALL have port blk_count, output, CNT_W, blocks written this run.
REQ-017 SHALL have port err_code, output, 2: 0 none, 1 count mismatch, 2 config timeout, 3 stream timeout.

Function
REQ-018 SHALL implement states IDLE, CFG, GUARD, STREAM, DRAIN, DONE, ERR; all outputs registered.
REQ-019 IDLE/DONE with start=1 SHALL go to CFG, clear blk_count, err_code and done, and assert start_config for exactly the first CFG cycle.
REQ-020 CFG SHALL wait for config_done=1, then go to GUARD with the guard counter loaded to GUARD_CYCLES-1.
REQ-021 GUARD SHALL decrement each cycle; at 0 it SHALL go to STREAM and assert reader_start for exactly the first STREAM cycle; GUARD_CYCLES=0 SHALL skip GUARD.
REQ-022 In STREAM and DRAIN, every cycle with wr_strobe=1 SHALL increment blk_count, saturating at 2**CNT_W-1.
REQ-023 STREAM with writer_done=1 SHALL compare blk_count, including a wr_strobe in the same cycle, with IMAGE_DEPTH; on equality it SHALL go to DRAIN, otherwise to ERR with err_code=1.
REQ-024 DRAIN SHALL count DRAIN_CYCLES cycles, then go to DONE; done SHALL be high throughout DONE.
REQ-025 busy SHALL be high in CFG, GUARD, STREAM and DRAIN only.
REQ-026 ERR SHALL hold error=1 and err_code until abort; start SHALL be ignored in ERR.
REQ-027 abort=1 SHALL go to IDLE next cycle from any state, with precedence over start and all other transitions; it SHALL clear done, error, err_code and the counters and suppress any pending pulse.
REQ-028 config_done or writer_done outside their waiting state SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, and all outputs and counters SHALL be 0.
REQ-030 Reset mid-run SHALL behave as abort, with no pulse emitted after release.

Configuration
REQ-031 With AES_PIPE_CTRL_TIMEOUT_EN defined, a cycle counter SHALL run in CFG and STREAM, cleared on each state entry.
REQ-032 When the counter reaches TIMEOUT_CYCLES, the block SHALL go to ERR with err_code=2 (CFG) or 3 (STREAM).
REQ-033 Without AES_PIPE_CTRL_TIMEOUT_EN, no watchdog logic SHALL exist, the block SHALL wait indefinitely, and err_code values 2 and 3 SHALL never occur.

Structure
REQ-034 Package aes_pipe_pkg SHALL hold the state enum, the err_code enum and default parameter constants.
REQ-035 One sub-module, pipe_down_counter (load/decrement/zero flag), SHALL be used for the GUARD and DRAIN counts; all other logic SHALL be in aes_pipeline_ctrl.

Verification
REQ-036 Nominal run: start pulse; config_done 30 cycles later; 64 wr_strobes; writer_done -> reader_start exactly 20 cycles after config_done, done 16 cycles after writer_done, blk_count=64.
REQ-037 Mismatch: 63 wr_strobes, then writer_done -> ERR, error=1, err_code=1, done=0.
REQ-038 Abort in GUARD at cycle 5 -> IDLE next cycle, reader_start never pulses, busy=0.
REQ-039 Timeout (macro on, TIMEOUT_CYCLES=100): config_done withheld -> err_code=2 at 100 cycles in CFG; macro off -> still CFG after 1000 cycles.
REQ-040 Last wr_strobe coincident with writer_done -> DRAIN (no error), blk_count=64.
REQ-041 rst_n low mid-STREAM -> all outputs 0 immediately; after release, start restarts a clean run.

Source files
------------

// File: rtl/aes_pipe_pkg.sv
// aes_pipe_pkg: state/error encodings and default sizing for the
// AES pipeline controller.
package aes_pipe_pkg;

  localparam int IMAGE_DEPTH_D    = 64;
  localparam int CNT_W_D          = 7;
  localparam int GUARD_CYCLES_D   = 20;
  localparam int DRAIN_CYCLES_D   = 16;
  localparam int TIMEOUT_CYCLES_D = 65535;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_GUARD,
    S_STREAM,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_COUNT     = 2'd1,
    ERR_CFG_TO    = 2'd2,
    ERR_STREAM_TO = 2'd3
  } err_t;

endpackage

// File: rtl/pipe_down_counter.sv
// pipe_down_counter: loadable down counter that stops at zero;
// shared by the GUARD and DRAIN phases.
module pipe_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/aes_pipeline_ctrl.sv
// aes_pipeline_ctrl: sequences config -> guard -> stream -> drain for one
// image run. Optional watchdog: define AES_PIPE_CTRL_TIMEOUT_EN.
module aes_pipeline_ctrl
  import aes_pipe_pkg::*;
#(
  parameter int IMAGE_DEPTH    = IMAGE_DEPTH_D,
  parameter int CNT_W          = CNT_W_D,
  parameter int GUARD_CYCLES   = GUARD_CYCLES_D,
  parameter int DRAIN_CYCLES   = DRAIN_CYCLES_D,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             start_config,
  input  logic             config_done,
  output logic             reader_start,
  input  logic             writer_done,
  input  logic             wr_strobe,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] blk_count,
  output logic [1:0]       err_code
);

  localparam int DMAX = (GUARD_CYCLES > DRAIN_CYCLES) ?
                        GUARD_CYCLES : DRAIN_CYCLES;
  localparam int DW = (DMAX < 2) ? 1 : $clog2(DMAX);
  localparam logic [CNT_W-1:0] BLK_MAX = '1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(IMAGE_DEPTH);

  if ((2 ** CNT_W) <= IMAGE_DEPTH || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("aes_pipeline_ctrl: invalid parameters");
  end

  state_t           state, state_n;
  err_t             fail_n, code_q, code_n;
  logic [CNT_W-1:0] blk_inc, blk_n;
  logic             cfg_pulse_n, rd_pulse_n;
  logic             busy_n, done_n, error_n;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [DW-1:0]    cnt_val;
  logic             wd_hit;

  assign blk_inc = (wr_strobe && blk_count != BLK_MAX) ?
                   blk_count + 1'b1 : blk_count;
  assign err_code = code_q;

  pipe_down_counter #(.W(DW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

`ifdef AES_PIPE_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] wd;
  logic          wd_run;

  assign wd_run = (state == S_CFG) || (state == S_STREAM);
  assign wd_hit = wd_run && (wd == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd <= '0;
    end else if (state_n != state) begin
      wd <= '0;
    end else if (wd_run) begin
      wd <= wd + 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      start_config <= 1'b0;
      reader_start <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      code_q       <= ERR_NONE;
      blk_count    <= '0;
    end else begin
      state        <= state_n;
      start_config <= cfg_pulse_n;
      reader_start <= rd_pulse_n;
      busy         <= busy_n;
      done         <= done_n;
      error        <= error_n;
      code_q       <= code_n;
      blk_count    <= blk_n;
    end
  end

  always_comb begin
    state_n = state;
    fail_n  = ERR_NONE;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) state_n = S_CFG;
      end
      S_CFG: begin
        if (config_done) begin
          state_n = (GUARD_CYCLES == 0) ? S_STREAM : S_GUARD;
        end else if (wd_hit) begin
          state_n = S_ERR;
          fail_n  = ERR_CFG_TO;
        end
      end
      S_GUARD: begin
        if (cnt_zero) state_n = S_STREAM;
      end
      S_STREAM: begin
        if (writer_done) begin
          if (blk_inc == DEPTH) begin
            state_n = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
          end else begin
            state_n = S_ERR;
            fail_n  = ERR_COUNT;
          end
        end else if (wd_hit) begin
          state_n = S_ERR;
          fail_n  = ERR_STREAM_TO;
        end
      end
      S_DRAIN: begin
        if (cnt_zero) state_n = S_DONE;
      end
      S_ERR: begin
        state_n = S_ERR;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort) begin
      state_n = S_IDLE;
      fail_n  = ERR_NONE;
    end
  end

  always_comb begin
    cfg_pulse_n = (state_n == S_CFG) && (state != S_CFG);
    rd_pulse_n  = (state_n == S_STREAM) && (state != S_STREAM);
    busy_n  = state_n inside {S_CFG, S_GUARD, S_STREAM, S_DRAIN};
    done_n  = (state_n == S_DONE);
    error_n = (state_n == S_ERR);
    code_n  = ERR_NONE;
    if (state_n == S_ERR) code_n = (state == S_ERR) ? code_q : fail_n;
    blk_n = blk_count;
    if (abort || cfg_pulse_n) begin
      blk_n = '0;
    end else if (state == S_STREAM || state == S_DRAIN) begin
      blk_n = blk_inc;
    end
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    if (abort) begin
      cnt_load = 1'b1;
    end else if (state_n == S_GUARD && state != S_GUARD) begin
      cnt_load = 1'b1;
      cnt_val  = DW'(GUARD_CYCLES - 1);
    end else if (state_n == S_DRAIN && state != S_DRAIN) begin
      cnt_load = 1'b1;
      cnt_val  = DW'(DRAIN_CYCLES - 1);
    end else begin
      cnt_dec = (state == S_GUARD) || (state == S_DRAIN);
    end
  end

endmodule
